dff_bank_arbiter: RTL and testbench

//  Round-robin arbiter and write sequencer for one shared WIDTH-bit register (bank of D flip-flops).
//  N_REQ requesters compete to load the register; the block picks one, loads its data and reports the owner.
//  A winner may hold ownership for a bounded burst via lock, writing every cycle while it holds.

---
 rtl/dff_bank_arbiter.sv | 124 ++++++++++++
 tb/tb_dff_bank_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// N_REQ requesters compete to load q; a winner may hold the register for a bounded burst via lock.
module dff_bank_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int WIDTH    = 8,
  parameter  int MAX_LOCK = 8,
  localparam int PW       = $clog2(N_REQ),
  localparam int CW       = $clog2(MAX_LOCK + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [PW-1:0]            owner,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic                     busy
);

  // Handshake: req[i] is held until gnt[i] is seen; gnt[i] acknowledges the write of
  // wdata[i] on the same posedge that raised it, and stays high for every burst cycle.

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_LOCK
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    lock_cnt;
  } ctl_t;

  ctl_t ctl;

  logic [WIDTH-1:0] wd [N_REQ];
  logic [PW-1:0]    win;
  logic [PW-1:0]    ptr_next;
  logic [N_REQ-1:0] win_oh;
  logic             burst_go;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      wd[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  // Scan from ptr upward; iterating downward lets the closest set bit overwrite the rest.
  always_comb begin
    int j;
    j   = 0;
    win = ctl.ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ctl.ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) win = PW'(j);
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
    ptr_next    = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
    burst_go    = lock[owner] && (ctl.lock_cnt < CW'(MAX_LOCK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl.state    <= S_IDLE;
      ctl.ptr      <= '0;
      ctl.lock_cnt <= '0;
      gnt          <= '0;
      owner        <= '0;
      q            <= '0;
      q_valid      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (ctl.state)
        S_IDLE: begin
          if (|req) begin
            gnt     <= win_oh;
            owner   <= win;
            q       <= wd[win];
            q_valid <= 1'b1;
            ctl.ptr <= ptr_next;
            busy    <= 1'b1;
            if (lock[win]) begin
              ctl.state    <= S_LOCK;
              ctl.lock_cnt <= CW'(1);
            end else begin
              ctl.state <= S_GRANT;
            end
          end
        end
        S_GRANT: begin
          gnt       <= '0;
          busy      <= 1'b0;
          ctl.state <= S_IDLE;
        end
        S_LOCK: begin
          if (burst_go) begin
            q            <= wd[owner];
            ctl.lock_cnt <= ctl.lock_cnt + 1'b1;
          end else begin
            gnt          <= '0;
            busy         <= 1'b0;
            ctl.lock_cnt <= '0;
            ctl.state    <= S_IDLE;
          end
        end
        default: begin
          gnt          <= '0;
          busy         <= 1'b0;
          ctl.lock_cnt <= '0;
          ctl.state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed scenarios plus random traffic, checked per cycle
// against a behavioural model through an expected-output queue.
module tb_dff_bank_arbiter;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_LOCK = 8;
  localparam int PW       = 2;
  localparam int W        = N_REQ + PW + WIDTH + 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [PW-1:0]          owner;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic                   busy;

  logic [WIDTH-1:0] wd [N_REQ];

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // model state: mode 0 = idle, 1 = single write, 2 = burst
  int               m_mode   = 0;
  int               m_writes = 0;
  int               m_ptr    = 0;
  int               m_owner  = 0;
  logic [N_REQ-1:0] m_gnt    = '0;
  logic [WIDTH-1:0] m_q      = '0;
  logic             m_qv     = 1'b0;

  dff_bank_arbiter #(
    .N_REQ(N_REQ),
    .WIDTH(WIDTH),
    .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .lock(lock),
    .wdata(wdata),
    .gnt(gnt),
    .owner(owner),
    .q(q),
    .q_valid(q_valid),
    .busy(busy)
  );

  // clock / packing
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) wdata[i*WIDTH +: WIDTH] = wd[i];
  end

  // reference model: one call per posedge, inputs as sampled at that edge
  task automatic model_clock();
    int w;
    int idx;
    if (rst) begin
      m_mode = 0; m_writes = 0; m_ptr = 0; m_owner = 0;
      m_gnt = '0; m_q = '0; m_qv = 1'b0;
    end else if (m_mode == 0) begin
      if (req != '0) begin
        w = -1;
        for (int k = 0; k < N_REQ; k++) begin
          idx = (m_ptr + k) % N_REQ;
          if (w < 0 && req[idx]) w = idx;
        end
        m_owner = w;
        m_q     = wd[w];
        m_qv    = 1'b1;
        m_ptr   = (w + 1) % N_REQ;
        m_gnt   = '0;
        m_gnt[w] = 1'b1;
        if (lock[w]) begin
          m_mode = 2; m_writes = 1;
        end else begin
          m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      m_gnt = '0; m_mode = 0;
    end else begin
      if (lock[m_owner] && m_writes < MAX_LOCK) begin
        m_q = wd[m_owner];
        m_writes++;
      end else begin
        m_gnt = '0; m_mode = 0; m_writes = 0;
      end
    end
    exp_q.push_back({m_gnt, PW'(m_owner), m_q, m_qv, (m_mode != 0)});
  endtask

  // driver: inputs are changed only 1 time unit after a posedge
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_idle();
    req = '0; lock = '0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {gnt, owner, q, q_valid, busy};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got gnt=%b owner=%0d q=%h q_valid=%b busy=%b exp gnt=%b owner=%0d q=%h q_valid=%b busy=%b",
                 $time, a[W-1 -: N_REQ], a[W-N_REQ-1 -: PW], a[WIDTH+1:2], a[1], a[0],
                 e[W-1 -: N_REQ], e[W-N_REQ-1 -: PW], e[WIDTH+1:2], e[1], e[0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = '1;
    lock = '0;
    for (int i = 0; i < N_REQ; i++) wd[i] = '0;

    // reset held with all requests high
    step(); step();
    rst = 1'b0;

    // single write from requester 2
    req = 4'b0100; wd[2] = 8'hA5;
    step();
    set_idle();
    step(); step();

    // round robin from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 9; c++) step();
    set_idle();
    step();

    // burst of three writes from requester 1
    req = 4'b0010; lock = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      wd[1] = WIDTH'(c);
      step();
    end
    set_idle();
    step(); step();

    // forced release with requester 3 pending
    req = 4'b0001; lock = 4'b0001; wd[0] = 8'h10;
    step();
    req = 4'b1001;
    for (int c = 0; c < 12; c++) begin
      wd[0] = WIDTH'(8'h11 + c);
      wd[3] = WIDTH'(8'hC0 + c);
      step();
      if (gnt[3]) req = 4'b0000;
    end
    set_idle();
    step();

    // reset in the middle of a burst, then arbitration from index 0
    req = 4'b0100; lock = 4'b0100; wd[2] = 8'h5A;
    step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; lock = '0;
    step(); step(); step();
    set_idle();
    step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      req  = N_REQ'($urandom_range(0, 15));
      if ((i % 80) < 30) lock = '1;
      else lock = N_REQ'($urandom_range(0, 15) | $urandom_range(0, 15));
      for (int k = 0; k < N_REQ; k++) wd[k] = WIDTH'($urandom_range(0, 255));
      step();
    end
    rst = 1'b0;
    set_idle();
    step();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
